// File: rtl/blocking_error.sv
// Gate d = (a | b) & c with a clocked checker comparing a correctly ordered registered copy of d
// against a copy that uses the intermediate term one cycle late.
module blocking_error #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             d,
    output logic             x,
    output logic             d_q,
    output logic             d_stale,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt
);

    logic x_q;
    logic cnt_full;

    // Continuous assignments keep x and d live with no clock and through reset.
    assign x = a | b;
    assign d = x & c;

    assign mismatch = d_q ^ d_stale;
    assign cnt_full = &mismatch_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q          <= 1'b0;
            d_q          <= 1'b0;
            d_stale      <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            x_q     <= x;
            d_q     <= d;
            // Uses last cycle's intermediate: the ordering bug this block demonstrates.
            d_stale <= x_q & c;
            if (mismatch && !cnt_full) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_blocking_error.sv
// Directed bench for blocking_error; an edge-indexed input log serves as the reference model.
module tb_blocking_error;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a = 1'b0;
    logic        b = 1'b0;
    logic        c = 1'b0;
    logic        d, x, d_q, d_stale, mismatch;
    logic [15:0] mismatch_cnt;
    logic        d2, x2, d_q2, d_stale2, mismatch2;
    logic [1:0]  mismatch_cnt2;

    bit clk_en = 1'b0;
    bit chk_en = 1'b0;
    int errors = 0;
    int checks = 0;

    blocking_error #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d), .x(x), .d_q(d_q),
        .d_stale(d_stale), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
    );

    blocking_error #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d2), .x(x2), .d_q(d_q2),
        .d_stale(d_stale2), .mismatch(mismatch2), .mismatch_cnt(mismatch_cnt2)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Model: log (a|b, c) as sampled at each non-reset edge since the last reset.
    bit ab_log [0:4095];
    bit c_log  [0:4095];
    int n = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n <= 0;
        end else begin
            ab_log[n] <= a | b;
            c_log[n]  <= c;
            n         <= n + 1;
        end
    end

    // Outputs after the k-th edge since reset.
    function automatic bit exp_dq(input int k);
        return (k >= 1) ? (ab_log[k-1] & c_log[k-1]) : 1'b0;
    endfunction

    function automatic bit exp_ds(input int k);
        return (k >= 2) ? (ab_log[k-2] & c_log[k-1]) : 1'b0;
    endfunction

    function automatic int unsigned exp_mis_total();
        int unsigned t = 0;
        for (int k = 1; k < n; k++) begin
            if (exp_dq(k) != exp_ds(k)) t++;
        end
        return t;
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned max);
        return (v > max) ? max : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("d", 32'(d), 32'((a | b) & c));
            check("x", 32'(x), 32'(a | b));
            check("d_q", 32'(d_q), 32'(exp_dq(n)));
            check("d_stale", 32'(d_stale), 32'(exp_ds(n)));
            check("mismatch", 32'(mismatch), 32'(exp_dq(n) ^ exp_ds(n)));
            check("cnt16", 32'(mismatch_cnt), sat(exp_mis_total(), 65535));
            check("cnt2", 32'(mismatch_cnt2), sat(exp_mis_total(), 3));
            check("d_q2", 32'(d_q2), 32'(exp_dq(n)));
        end
    end

    task automatic edge_step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int unsigned cb;

        // Unclocked sweep: a every 10 ns, b every 50 ns, c every 100 ns.
        for (int t = 0; t < 300; t++) begin
            a = t[0];
            b = ((t / 5) % 2) == 1;
            c = ((t / 10) % 2) == 1;
            #1;
            check("sweep_d", 32'(d), 32'((a | b) & c));
            check("sweep_x", 32'(x), 32'(a | b));
            #9;
        end
        a = 1; b = 0; c = 1; #1; check("pt101", 32'(d), 32'd1);
        a = 0; b = 0; c = 1; #1; check("pt001", 32'(d), 32'd0);
        a = 1; b = 1; c = 0; #1; check("pt110", 32'(d), 32'd0);

        // Reset phase: build up a nonzero count, then assert reset between edges.
        a = 1; b = 1; c = 1;
        reset = 1;
        clk_en = 1;
        repeat (2) edge_step();
        reset = 0;
        chk_en = 1;
        repeat (4) edge_step();
        check("pre_reset_cnt", 32'(mismatch_cnt), 32'd1);
        reset = 1;
        #1;
        check("rst_dq", 32'(d_q), 32'd0);
        check("rst_ds", 32'(d_stale), 32'd0);
        check("rst_cnt", 32'(mismatch_cnt), 32'd0);
        check("rst_cnt2", 32'(mismatch_cnt2), 32'd0);
        check("rst_d", 32'(d), 32'd1);
        edge_step();
        check("rst_d_edge", 32'(d), 32'd1);
        check("rst_hold_dq", 32'(d_q), 32'd0);

        // Stable inputs after release.
        a = 1; b = 0; c = 1;
        reset = 0;
        edge_step();
        check("e1_dq", 32'(d_q), 32'd1);
        check("e1_ds", 32'(d_stale), 32'd0);
        check("e1_mis", 32'(mismatch), 32'd1);
        edge_step();
        check("e2_ds", 32'(d_stale), 32'd1);
        check("e2_mis", 32'(mismatch), 32'd0);
        check("e2_cnt", 32'(mismatch_cnt), 32'd1);

        // Transition: a|b falls while c stays 1.
        a = 0;
        cb = 32'(mismatch_cnt);
        edge_step();
        check("tr_dq", 32'(d_q), 32'd0);
        check("tr_ds", 32'(d_stale), 32'd1);
        check("tr_mis", 32'(mismatch), 32'd1);
        edge_step();
        check("tr_mis_clear", 32'(mismatch), 32'd0);
        check("tr_cnt", 32'(mismatch_cnt), cb + 1);

        // Masking: c = 0 with a toggling every cycle.
        c = 0;
        edge_step();
        cb = 32'(mismatch_cnt);
        for (int i = 0; i < 20; i++) begin
            a = ~a;
            edge_step();
            check("mask_mis", 32'(mismatch), 32'd0);
        end
        check("mask_cnt", 32'(mismatch_cnt), cb);

        // Saturation: a mismatch every other cycle.
        c = 1;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) a = ~a;
            edge_step();
        end
        check("sat_cnt2", 32'(mismatch_cnt2), 32'd3);
        check("sat_cnt16", 32'(mismatch_cnt), cb + 10);
        repeat (4) edge_step();
        check("sat_hold", 32'(mismatch_cnt2), 32'd3);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/blocking_error.md
Name: blocking_error

Overview:
- Combinational gate `d = (a | b) & c`, plus a clocked checker beside it.
- The checker compares a correctly ordered registered copy of `d` against a "stale-intermediate" copy. The stale copy models the bug where `d` is evaluated before its intermediate term `x` is updated.
- The block sits in the training/regression area as a reference for blocking-assignment ordering hazards.
- `d` must stay valid with `clk` and `reset` left unconnected. An unclocked stimulus (toggling `a`, `b`, `c` only) checks `d` alone.

Parameters:
- CNT_W, default 16: width of the mismatch counter; minimum 1.

Ports:
- clk  input  1  rising-edge clock for the checker logic.
- reset  input  1  asynchronous, active-high; clears all registers.
- a  input  1  data input.
- b  input  1  data input.
- c  input  1  data input.
- d  output  1  combinational `(a | b) & c`.
- x  output  1  combinational intermediate `a | b`.
- d_q  output  1  registered `d`.
- d_stale  output  1  registered misordered model.
- mismatch  output  1  combinational, `d_q != d_stale`.
- mismatch_cnt  output  CNT_W  saturating count of clock edges at which mismatch was 1.

Behaviour:
- `d` and `x`:
  - Purely combinational. They are independent of `clk` and `reset`, including while `reset` is asserted.
  - With no clock at all, `d` must update within the same delta/timestep as any change on `a`, `b` or `c`.
  - The implementation must compute `x` before `d` (or use continuous assignments). `d` must never reflect a previous value of `a | b`.
- Reset: while `reset` = 1, all of the following are forced to 0 asynchronously, without waiting for a clock edge:
  - `x_q` (internal register)
  - `d_q`
  - `d_stale`
  - `mismatch_cnt`
- Reset deassertion: takes effect at the first rising `clk` edge after `reset` falls.
- Per rising `clk` edge, when `reset` = 0:
  - `x_q <= a | b`.
  - `d_q <= (a | b) & c`.
  - `d_stale <= x_q & c`, where `x_q` is the value held before this edge. This models the misordered evaluation.
  - If `mismatch` = 1 before the edge and `mismatch_cnt` != all-ones, `mismatch_cnt` increments by 1. Otherwise it holds.
  - At all-ones, `mismatch_cnt` saturates; it never wraps to 0.
- Latency:
  - `d_q`: 1 cycle.
  - `d_stale`: 1 cycle for the `c` term, 2 cycles for the `a | b` term.
  - `mismatch` follows `d_q` and `d_stale` combinationally.
- Inputs are sampled directly at the clock edge, with no synchronisers. The environment guarantees setup/hold timing.
- Boundary conditions:
  - `c` = 0 forces `d` = 0 and, at the next edge, `d_q` = `d_stale` = 0. No mismatch is possible in that cycle.
  - When `a | b` is constant for at least 2 cycles, `d_stale` equals `d_q`.
  - When `a | b` changes while `c` = 1, `mismatch` = 1 for exactly one cycle after the edge.
  - Reset asserted in mid-count clears `mismatch_cnt` immediately. The count restarts from 0 after release.
  - When clock edges coincide with input changes, the values before the change are the ones sampled.
- Must be synthesisable: no latches, no initial blocks, and no `x`/`z` on outputs after reset.

Test Plan:
- Unclocked sweep: toggle `a` every 10 ns, `b` every 50 ns, `c` every 100 ns for 3000 ns with `clk`/`reset` idle.
  - Required: `d` == `(a|b)&c` at every change.
  - Example points: (a,b,c) = (1,0,1) -> `d` = 1; (0,0,1) -> `d` = 0; (1,1,0) -> `d` = 0.
- Reset: set `a` = `b` = `c` = 1 and clock several cycles, then assert `reset` between edges.
  - Required: `d_q`, `d_stale` and `mismatch_cnt` drop to 0 immediately.
  - Required: `d` stays 1 throughout.
- Stable inputs: after reset release, hold `c` = 1, `a` = 1, `b` = 0.
  - Required: edge 1 gives `d_q` = 1, `d_stale` = 0, `mismatch` = 1.
  - Required: edge 2 gives `d_stale` = 1, `mismatch` = 0, and `mismatch_cnt` = 1.
- Transition: hold `c` = 1 and drop `a | b` from 1 to 0 one cycle before an edge.
  - Required: after the edge, `d_q` = 0 and `d_stale` = 1, so `mismatch` = 1 for one cycle.
  - Required: `mismatch_cnt` increments by exactly 1.
- Masking: hold `c` = 0 and toggle `a` every cycle for 20 cycles.
  - Required: `mismatch` = 0 throughout.
  - Required: `mismatch_cnt` unchanged.
- Saturation: with CNT_W = 2, force a mismatch every other cycle for 20 cycles.
  - Required: `mismatch_cnt` reaches 3 and holds at 3.
